// File: rtl/vec_pkg.sv
// Shared vector-unit definitions: lane geometry, index widths, sequencer state
// encoding and op-length helpers.
package vec_pkg;

    localparam int unsigned LANES    = 4;
    localparam int unsigned VLEN_MAX = 16;
    localparam int unsigned ELEM_W   = 16;
    localparam int unsigned BEAT_W   = 2;
    localparam int unsigned EIDX_W   = 4;
    localparam int unsigned LEN_W    = 5;
    localparam int unsigned CNT_W    = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } seq_state_t;

    // Scalar ops occupy one lane; vector lengths saturate at the register width.
    function automatic logic [LEN_W-1:0] op_eff_len(input logic             is_vector,
                                                    input logic [LEN_W-1:0] vlen);
        if (!is_vector)
            return LEN_W'(1);
        if (vlen > LEN_W'(VLEN_MAX))
            return LEN_W'(VLEN_MAX);
        return vlen;
    endfunction

    function automatic logic [LEN_W-1:0] op_beats(input logic [LEN_W-1:0] len);
        return (len + LEN_W'(LANES - 1)) >> 2;
    endfunction

endpackage

// File: rtl/lane_mask_gen.sv
// Per-beat lane enable mask: lane i is live when 4*beat + i is below the op length.
module lane_mask_gen
    import vec_pkg::*;
(
    input  logic [LEN_W-1:0]  op_len,
    input  logic [BEAT_W-1:0] beat,
    output logic [LANES-1:0]  mask
);

    logic [LEN_W-1:0] base;

    always_comb begin
        base = LEN_W'({beat, 2'b00});
        mask = '0;
        for (int unsigned i = 0; i < LANES; i++)
            mask[i] = (base + LEN_W'(i)) < op_len;
    end

endmodule

// File: rtl/vector_lane_sequencer.sv
// Splits a decoded scalar/vector op into 4-lane beats, then waits PIPE_LAT
// cycles for the pipes to retire it before pulsing done.
module vector_lane_sequencer
    import vec_pkg::*;
#(
    parameter int unsigned PIPE_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_is_vector,
    input  logic [LEN_W-1:0]  req_vlen,
    input  logic              flush,
    output logic              stall,
    output logic              issue_valid,
    output logic [LANES-1:0]  lane_en,
    output logic [BEAT_W-1:0] beat_idx,
    output logic [EIDX_W-1:0] elem_base,
    output logic              last_beat,
    output logic              done
);

    seq_state_t        state_q, state_nxt;
    logic [LEN_W-1:0]  len_q, len_nxt;
    logic [BEAT_W-1:0] beat_q, beat_nxt;
    logic [CNT_W-1:0]  cnt_q, cnt_nxt;

    logic [LEN_W-1:0]  req_len;
    logic [LEN_W-1:0]  nbeats;
    logic              at_last;
    logic              accept;
    logic [LANES-1:0]  mask;

    lane_mask_gen u_mask (
        .op_len (len_q),
        .beat   (beat_q),
        .mask   (mask)
    );

    assign req_len = op_eff_len(req_is_vector, req_vlen);
    assign nbeats  = op_beats(len_q);
    assign at_last = LEN_W'(beat_q) == (nbeats - LEN_W'(1));
    assign accept  = req_valid && req_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            len_q   <= '0;
            beat_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_nxt;
            len_q   <= len_nxt;
            beat_q  <= beat_nxt;
            cnt_q   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        len_nxt   = len_q;
        beat_nxt  = beat_q;
        cnt_nxt   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    len_nxt  = req_len;
                    beat_nxt = '0;
                    if (req_len == '0) begin
                        state_nxt = DRAIN;
                        cnt_nxt   = CNT_W'(PIPE_LAT);
                    end else begin
                        state_nxt = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (flush) begin
                    state_nxt = IDLE;
                    beat_nxt  = '0;
                end else if (at_last) begin
                    state_nxt = DRAIN;
                    beat_nxt  = '0;
                    cnt_nxt   = CNT_W'(PIPE_LAT);
                end else begin
                    beat_nxt = beat_q + BEAT_W'(1);
                end
            end
            DRAIN: begin
                if (flush) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt_q == CNT_W'(1)) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                beat_nxt  = '0;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Beat outputs come from registered state; flush only gates them off.
    always_comb begin
        req_ready   = (state_q == IDLE) && !flush;
        stall       = !req_ready;
        issue_valid = (state_q == ISSUE) && !flush;
        lane_en     = issue_valid ? mask : '0;
        beat_idx    = issue_valid ? beat_q : '0;
        elem_base   = {beat_idx, 2'b00};
        last_beat   = issue_valid && at_last;
        done        = (state_q == DRAIN) && (cnt_q == CNT_W'(1)) && !flush;
    end

endmodule

// File: tb/tb_vector_lane_sequencer.sv
// Directed bench for vector_lane_sequencer: table of ops with hand-computed
// beat masks, plus flush, async reset and back-to-back sequences.
module tb_vector_lane_sequencer;

    localparam int LAT = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    logic       req_is_vector;
    logic [4:0] req_vlen;
    logic       flush;
    logic       stall;
    logic       issue_valid;
    logic [3:0] lane_en;
    logic [1:0] beat_idx;
    logic [3:0] elem_base;
    logic       last_beat;
    logic       done;

    int n_chk = 0;
    int n_bad = 0;

    vector_lane_sequencer #(.PIPE_LAT(LAT)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_is_vector (req_is_vector),
        .req_vlen      (req_vlen),
        .flush         (flush),
        .stall         (stall),
        .issue_valid   (issue_valid),
        .lane_en       (lane_en),
        .beat_idx      (beat_idx),
        .elem_base     (elem_base),
        .last_beat     (last_beat),
        .done          (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        is_vec;
        logic [4:0]  vlen;
        int          nb;     // expected beat count
        logic [15:0] masks;  // beat k mask in bits [4k+3:4k]
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_quiet(input string nm);
        chk({nm, "_iv"}, 32'(issue_valid), 0);
        chk({nm, "_lane"}, 32'(lane_en), 0);
        chk({nm, "_beat"}, 32'(beat_idx), 0);
        chk({nm, "_base"}, 32'(elem_base), 0);
        chk({nm, "_last"}, 32'(last_beat), 0);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!req_ready && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("wait_ready", 32'(req_ready), 1);
    endtask

    // Called at a negedge in an idle cycle T; returns at the negedge of T+nb+LAT+1.
    task automatic run_entry(input vec_t v);
        logic [3:0] m;
        req_valid     = 1'b1;
        req_is_vector = v.is_vec;
        req_vlen      = v.vlen;
        #1;
        chk("accept_ready", 32'(req_ready), 1);
        chk("accept_stall", 32'(stall), 0);
        @(negedge clk);
        req_valid = 1'b0;
        for (int k = 0; k < v.nb; k++) begin
            m = v.masks[k*4 +: 4];
            chk("beat_iv", 32'(issue_valid), 1);
            chk("beat_lane", 32'(lane_en), 32'(m));
            chk("beat_idx", 32'(beat_idx), 32'(k));
            chk("beat_base", 32'(elem_base), 32'(4 * k));
            chk("beat_last", 32'(last_beat), 32'(k == v.nb - 1));
            chk("beat_done", 32'(done), 0);
            chk("beat_stall", 32'(stall), 1);
            @(negedge clk);
        end
        for (int d = 1; d <= LAT; d++) begin
            chk_quiet("drain");
            chk("drain_done", 32'(done), 32'(d == LAT));
            chk("drain_stall", 32'(stall), 1);
            @(negedge clk);
        end
        chk("ready_again", 32'(req_ready), 1);
        chk("done_off", 32'(done), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{1'b1, 5'd6,  2, 16'h003F};
        tbl[1] = '{1'b1, 5'd16, 4, 16'hFFFF};
        tbl[2] = '{1'b1, 5'd20, 4, 16'hFFFF};
        tbl[3] = '{1'b0, 5'd9,  1, 16'h0001};
        tbl[4] = '{1'b1, 5'd0,  0, 16'h0000};
        tbl[5] = '{1'b1, 5'd1,  1, 16'h0001};
        tbl[6] = '{1'b1, 5'd5,  2, 16'h001F};
        tbl[7] = '{1'b1, 5'd15, 4, 16'h7FFF};
        tbl[8] = '{1'b1, 5'd31, 4, 16'hFFFF};

        rst = 1'b1; req_valid = 1'b0; req_is_vector = 1'b0; req_vlen = '0; flush = 1'b0;
        #1;
        chk_quiet("rst");
        chk("rst_done", 32'(done), 0);
        chk("rst_ready", 32'(req_ready), 1);
        chk("rst_stall", 32'(stall), 0);
        flush = 1'b1;
        #1;
        chk("rst_flush_ready", 32'(req_ready), 0);
        chk("rst_flush_stall", 32'(stall), 1);
        flush = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            wait_ready();
            run_entry(tbl[i]);
        end

        // flush while idle blocks acceptance
        req_valid = 1'b1; req_is_vector = 1'b1; req_vlen = 5'd8; flush = 1'b1;
        #1;
        chk("idle_flush_ready", 32'(req_ready), 0);
        chk("idle_flush_stall", 32'(stall), 1);
        @(negedge clk);
        req_valid = 1'b0; flush = 1'b0;
        #1;
        chk("idle_flush_noacc", 32'(issue_valid), 0);
        chk("idle_flush_idle", 32'(req_ready), 1);

        // flush at T+2 of a vlen=16 op, then new op accepted at T+3
        req_valid = 1'b1; req_is_vector = 1'b1; req_vlen = 5'd16;
        @(negedge clk);
        req_valid = 1'b0;
        chk("fl_t1_iv", 32'(issue_valid), 1);
        chk("fl_t1_lane", 32'(lane_en), 32'hF);
        @(negedge clk);
        flush = 1'b1;
        #1;
        chk_quiet("fl_t2");
        chk("fl_t2_done", 32'(done), 0);
        chk("fl_t2_ready", 32'(req_ready), 0);
        @(negedge clk);
        flush = 1'b0;
        #1;
        chk_quiet("fl_t3");
        chk("fl_t3_done", 32'(done), 0);
        run_entry(tbl[0]);

        // flush during DRAIN suppresses done
        req_valid = 1'b1; req_is_vector = 1'b1; req_vlen = 5'd4;
        @(negedge clk);
        req_valid = 1'b0;
        chk("fd_beat_last", 32'(last_beat), 1);
        @(negedge clk);
        @(negedge clk);
        flush = 1'b1;
        #1;
        chk("fd_done", 32'(done), 0);
        @(negedge clk);
        flush = 1'b0;
        #1;
        chk("fd_ready", 32'(req_ready), 1);
        chk("fd_done_after", 32'(done), 0);
        @(negedge clk);

        // async reset mid-ISSUE
        req_valid = 1'b1; req_is_vector = 1'b1; req_vlen = 5'd16;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        chk("ar_pre_iv", 32'(issue_valid), 1);
        chk("ar_pre_beat", 32'(beat_idx), 1);
        #2 rst = 1'b1;
        #1;
        chk_quiet("ar");
        chk("ar_done", 32'(done), 0);
        chk("ar_ready", 32'(req_ready), 1);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk("ar_post_iv", 32'(issue_valid), 0);
            chk("ar_post_done", 32'(done), 0);
            chk("ar_post_ready", 32'(req_ready), 1);
            @(negedge clk);
        end

        // back-to-back: vlen=4 at T, vlen=8 held valid, accepted at T+4
        req_valid = 1'b1; req_is_vector = 1'b1; req_vlen = 5'd4;
        #1;
        chk("bb_t0_ready", 32'(req_ready), 1);
        @(negedge clk);
        req_vlen = 5'd8;
        #1;
        chk("bb_t1_stall", 32'(stall), 1);
        chk("bb_t1_iv", 32'(issue_valid), 1);
        chk("bb_t1_lane", 32'(lane_en), 32'hF);
        chk("bb_t1_last", 32'(last_beat), 1);
        @(negedge clk);
        chk("bb_t2_stall", 32'(stall), 1);
        chk("bb_t2_iv", 32'(issue_valid), 0);
        chk("bb_t2_done", 32'(done), 0);
        @(negedge clk);
        chk("bb_t3_stall", 32'(stall), 1);
        chk("bb_t3_done", 32'(done), 1);
        chk("bb_t3_iv", 32'(issue_valid), 0);
        @(negedge clk);
        chk("bb_t4_ready", 32'(req_ready), 1);
        chk("bb_t4_stall", 32'(stall), 0);
        chk("bb_t4_iv", 32'(issue_valid), 0);
        @(negedge clk);
        req_valid = 1'b0;
        chk("bb_t5_lane", 32'(lane_en), 32'hF);
        chk("bb_t5_base", 32'(elem_base), 0);
        chk("bb_t5_last", 32'(last_beat), 0);
        @(negedge clk);
        chk("bb_t6_lane", 32'(lane_en), 32'hF);
        chk("bb_t6_base", 32'(elem_base), 4);
        chk("bb_t6_last", 32'(last_beat), 1);
        @(negedge clk);
        chk("bb_t7_iv", 32'(issue_valid), 0);
        chk("bb_t7_done", 32'(done), 0);
        @(negedge clk);
        chk("bb_t8_done", 32'(done), 1);
        @(negedge clk);
        chk("bb_t9_ready", 32'(req_ready), 1);
        chk("bb_t9_iv", 32'(issue_valid), 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
